// File: rtl/puf_pkg.sv
// +------------------------------------------------------------------+
// | puf_pkg: shared types, defaults and select helper for the RO-PUF |
// | measurement sequencer.                             Rev 1.0       |
// +------------------------------------------------------------------+
`default_nettype none

package puf_pkg;

  localparam int SEL_W = 5;

  localparam int DEF_CLR_CYCLES    = 2;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_WINDOW_CYCLES = 256;
  localparam int DEF_SYNC_CYCLES   = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_HOLD    = 3'd4,
    ST_COMPARE = 3'd5,
    ST_DONE    = 3'd6
  } puf_state_e;

  // Oscillator select for bit idx: base + 2*idx (+1 for bank B), wrapping mod 32.
  function automatic logic [SEL_W-1:0] chal_sel(input logic [SEL_W-1:0] base,
                                                input logic [SEL_W-1:0] idx,
                                                input logic             odd);
    logic [SEL_W-1:0] two_k;
    two_k = {idx[SEL_W-2:0], 1'b0};
    return base + two_k + {{(SEL_W-1){1'b0}}, odd};
  endfunction

endpackage

`default_nettype wire

// File: rtl/puf_measure_ctrl_if.sv
// +------------------------------------------------------------------+
// | puf_measure_ctrl_if: pin/counter-side bundle of the PUF sequencer.|
// |                                                    Rev 1.0       |
// +------------------------------------------------------------------+
`default_nettype none

interface puf_measure_ctrl_if #(
  parameter int N_BITS = 8,
  parameter int CW     = 32
) ();
  import puf_pkg::*;

  logic              start;
  logic              abort;
  logic [SEL_W-1:0]  chal_base;
  logic [CW-1:0]     count_a;
  logic [CW-1:0]     count_b;
  logic [SEL_W-1:0]  sel_a;
  logic [SEL_W-1:0]  sel_b;
  logic              osc_en;
  logic              cnt_clr;
  logic              busy;
  logic              done;
  logic [N_BITS-1:0] response;
  logic              tie_flag;

  modport master (
    output start, abort, chal_base, count_a, count_b,
    input  sel_a, sel_b, osc_en, cnt_clr, busy, done, response, tie_flag
  );

  modport slave (
    input  start, abort, chal_base, count_a, count_b,
    output sel_a, sel_b, osc_en, cnt_clr, busy, done, response, tie_flag
  );

endinterface

`default_nettype wire

// File: rtl/puf_phase_timer.sv
// +------------------------------------------------------------------+
// | puf_phase_timer: loadable down-counter timing each FSM phase.    |
// |                                                    Rev 1.0       |
// +------------------------------------------------------------------+
`default_nettype none

module puf_phase_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiring at 1 lets a phase of length L end exactly after L cycles.
  assign expire_o = (cnt_q == W'(1));

endmodule

`default_nettype wire

// File: rtl/puf_measure_ctrl.sv
// +------------------------------------------------------------------+
// | puf_measure_ctrl: walks a challenge base through N_BITS RO-pair  |
// | measurements and assembles the PUF response.       Rev 1.0       |
// +------------------------------------------------------------------+
`default_nettype none

module puf_measure_ctrl
  import puf_pkg::*;
#(
  parameter int N_BITS        = 8,
  parameter int CW            = 32,
  parameter int CLR_CYCLES    = DEF_CLR_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int SYNC_CYCLES   = DEF_SYNC_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  puf_measure_ctrl_if.slave  bus
);

  localparam int K_W    = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int PH_M1  = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int PH_M2  = (WINDOW_CYCLES > SYNC_CYCLES) ? WINDOW_CYCLES : SYNC_CYCLES;
  localparam int PH_MAX = (PH_M1 > PH_M2) ? PH_M1 : PH_M2;
  localparam int T_W    = $clog2(PH_MAX + 1);

  puf_state_e        state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [SEL_W-1:0]  base_q, base_d;
  logic [N_BITS-1:0] resp_q, resp_d;
  logic              tie_q, tie_d;
  logic [SEL_W-1:0]  sel_a_q, sel_a_d;
  logic [SEL_W-1:0]  sel_b_q, sel_b_d;
  logic              osc_en_q, osc_en_d;
  logic              cnt_clr_q, cnt_clr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tmr_load;
  logic [T_W-1:0]    tmr_val;
  logic              tmr_expire;
  logic              last_bit;

  assign last_bit = (k_q == K_W'(N_BITS - 1));

  puf_phase_timer #(.W(T_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_expire)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      base_q    <= '0;
      resp_q    <= '0;
      tie_q     <= 1'b0;
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      osc_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      base_q    <= base_d;
      resp_q    <= resp_d;
      tie_q     <= tie_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      osc_en_q  <= osc_en_d;
      cnt_clr_q <= cnt_clr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    resp_d  = resp_q;
    tie_d   = tie_q;
    if (state_q != ST_IDLE && bus.abort) begin
      state_d = ST_IDLE;
      k_d     = '0;
      resp_d  = '0;
      tie_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            state_d = ST_CLEAR;
            base_d  = bus.chal_base;
            k_d     = '0;
            resp_d  = '0;
            tie_d   = 1'b0;
          end
        end
        ST_CLEAR:   if (tmr_expire) state_d = ST_SETTLE;
        ST_SETTLE:  if (tmr_expire) state_d = ST_MEASURE;
        ST_MEASURE: if (tmr_expire) state_d = ST_HOLD;
        ST_HOLD:    if (tmr_expire) state_d = ST_COMPARE;
        ST_COMPARE: begin
          // A tie resolves to 0 and is remembered in the sticky flag.
          resp_d[k_q] = (bus.count_a > bus.count_b);
          if (bus.count_a == bus.count_b) begin
            tie_d = 1'b1;
          end
          if (last_bit) begin
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + K_W'(1);
            state_d = ST_CLEAR;
          end
        end
        ST_DONE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registers line up with it.
  always_comb begin
    osc_en_d  = (state_d == ST_MEASURE);
    cnt_clr_d = (state_d == ST_CLEAR);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    if (state_d == ST_CLEAR && state_q != ST_CLEAR) begin
      sel_a_d = chal_sel(base_d, SEL_W'(k_d), 1'b0);
      sel_b_d = chal_sel(base_d, SEL_W'(k_d), 1'b1);
    end
    tmr_load = (state_d != state_q);
    case (state_d)
      ST_CLEAR:   tmr_val = T_W'(CLR_CYCLES);
      ST_SETTLE:  tmr_val = T_W'(SETTLE_CYCLES);
      ST_MEASURE: tmr_val = T_W'(WINDOW_CYCLES);
      ST_HOLD:    tmr_val = T_W'(SYNC_CYCLES);
      default:    tmr_val = '0;
    endcase
  end

  assign bus.sel_a    = sel_a_q;
  assign bus.sel_b    = sel_b_q;
  assign bus.osc_en   = osc_en_q;
  assign bus.cnt_clr  = cnt_clr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.response = resp_q;
  assign bus.tie_flag = tie_q;

endmodule

`default_nettype wire

// File: tb/tb_puf_measure_ctrl.sv
// +------------------------------------------------------------------+
// | tb_puf_measure_ctrl: self-checking bench for puf_measure_ctrl.   |
// |                                                    Rev 1.0       |
// +------------------------------------------------------------------+
`default_nettype none

module tb_puf_measure_ctrl;

  localparam int N_BITS = 8;
  localparam int CW     = 32;
  localparam int CLR    = 2;
  localparam int SETTLE = 4;
  localparam int WIN    = 256;
  localparam int SYNC   = 4;
  localparam int P      = CLR + SETTLE + WIN + SYNC + 1;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [CW-1:0] ca [N_BITS];
  logic [CW-1:0] cb [N_BITS];

  always #5 clk = ~clk;

  puf_measure_ctrl_if #(.N_BITS(N_BITS), .CW(CW)) bus ();

  puf_measure_ctrl #(
    .N_BITS(N_BITS), .CW(CW), .CLR_CYCLES(CLR), .SETTLE_CYCLES(SETTLE),
    .WINDOW_CYCLES(WIN), .SYNC_CYCLES(SYNC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_counts();
    for (int k = 0; k < N_BITS; k++) begin
      ca[k] = CW'($urandom_range(0, 1000));
      cb[k] = ($urandom_range(0, 3) == 0) ? ca[k] : CW'($urandom_range(0, 1000));
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},    64'(bus.busy),     64'(0));
    check({tag, "_osc_en"},  64'(bus.osc_en),   64'(0));
    check({tag, "_cnt_clr"}, 64'(bus.cnt_clr),  64'(0));
    check({tag, "_done"},    64'(bus.done),     64'(0));
    check({tag, "_resp"},    64'(bus.response), 64'(0));
    check({tag, "_tie"},     64'(bus.tie_flag), 64'(0));
  endtask

  // One run from start; the cycle right after the start-sampling edge is cycle 1.
  task automatic do_run(input logic [4:0] base, input int restart_at,
                        input int abort_at, input string tag);
    int limit, idx, done_n, done_cyc, clr_n, osc_n, ovl;
    int first_clr, first_osc, cur_run, bad_runs;
    logic [N_BITS-1:0] exp_resp, resp_done;
    logic exp_tie, tie_done;
    exp_resp = '0;
    exp_tie  = 1'b0;
    for (int k = 0; k < N_BITS; k++) begin
      if (ca[k] > cb[k])  exp_resp[k] = 1'b1;
      if (ca[k] == cb[k]) exp_tie     = 1'b1;
    end
    limit = (abort_at > 0) ? abort_at + 40 : 1 + N_BITS * P + 3;
    done_n = 0; done_cyc = 0; clr_n = 0; osc_n = 0; ovl = 0;
    first_clr = 0; first_osc = 0; cur_run = 0; bad_runs = 0;
    resp_done = '0; tie_done = 1'b0;
    @(negedge clk);
    bus.chal_base = base;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      if (bus.cnt_clr) begin
        clr_n++;
        if (first_clr == 0) first_clr = c;
      end
      if (bus.osc_en) begin
        osc_n++;
        cur_run++;
        if (first_osc == 0) first_osc = c;
      end else if (cur_run != 0) begin
        if (cur_run != WIN) bad_runs++;
        cur_run = 0;
      end
      if (bus.osc_en && bus.cnt_clr) ovl++;
      if (bus.done) begin
        done_n++;
        done_cyc  = c;
        resp_done = bus.response;
        tie_done  = bus.tie_flag;
      end
      idx = (c - 1) / P;
      if (idx < N_BITS && (abort_at == 0 || c <= abort_at) &&
          ((c - 1) % P == 0 || c % P == 0)) begin
        check($sformatf("%s_sel_a_b%0d_c%0d", tag, idx, c), 64'(bus.sel_a),
              64'((int'(base) + 2 * idx) % 32));
        check($sformatf("%s_sel_b_b%0d_c%0d", tag, idx, c), 64'(bus.sel_b),
              64'((int'(base) + 2 * idx + 1) % 32));
      end
      if (abort_at > 0 && c == abort_at + 1) check_idle_zero({tag, "_after_abort"});
      if (c == restart_at) begin
        bus.start     = 1'b1;
        bus.chal_base = ~base;
      end else begin
        bus.start = 1'b0;
      end
      bus.abort = (c == abort_at);
      if (idx < N_BITS) begin
        bus.count_a = ca[idx];
        bus.count_b = cb[idx];
      end
      @(posedge clk); #1;
    end
    if (abort_at == 0) begin
      check({tag, "_done_count"},   64'(done_n),       64'(1));
      check({tag, "_done_cycle"},   64'(done_cyc),     64'(1 + N_BITS * P));
      check({tag, "_resp_at_done"}, 64'(resp_done),    64'(exp_resp));
      check({tag, "_tie_at_done"},  64'(tie_done),     64'(exp_tie));
      check({tag, "_resp_held"},    64'(bus.response), 64'(exp_resp));
      check({tag, "_tie_held"},     64'(bus.tie_flag), 64'(exp_tie));
      check({tag, "_busy_end"},     64'(bus.busy),     64'(0));
      check({tag, "_clr_cycles"},   64'(clr_n),        64'(N_BITS * CLR));
      check({tag, "_osc_cycles"},   64'(osc_n),        64'(N_BITS * WIN));
      check({tag, "_first_clr"},    64'(first_clr),    64'(1));
      check({tag, "_first_osc"},    64'(first_osc),    64'(1 + CLR + SETTLE));
      check({tag, "_bad_windows"},  64'(bad_runs),     64'(0));
    end else begin
      check({tag, "_no_done"},      64'(done_n),       64'(0));
    end
    check({tag, "_overlap"}, 64'(ovl), 64'(0));
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.chal_base = '0;
    bus.count_a   = '0;
    bus.count_b   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    check("reset_sel_a", 64'(bus.sel_a), 64'(0));
    check("reset_sel_b", 64'(bus.sel_b), 64'(0));
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    for (int k = 0; k < N_BITS; k++) begin
      ca[k] = (k % 2 == 0) ? CW'(100) : CW'(50);
      cb[k] = (k % 2 == 0) ? CW'(50)  : CW'(100);
    end
    do_run(5'd30, 0, 0, "alt");
    check("alt_resp_const", 64'(bus.response), 64'(8'b0101_0101));

    for (int k = 0; k < N_BITS; k++) begin
      ca[k] = (k == 3) ? CW'(77) : CW'(100 + k);
      cb[k] = (k == 3) ? CW'(77) : CW'(20 + k);
    end
    do_run(5'($urandom_range(0, 31)), 0, 0, "tie");
    check("tie_resp_const", 64'(bus.response), 64'(8'b1111_0111));
    check("tie_flag_const", 64'(bus.tie_flag), 64'(1));

    // Asynchronous reset while the oscillators are running.
    @(negedge clk);
    bus.chal_base = 5'($urandom_range(0, 31));
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("rst_mid_osc_pre", 64'(bus.osc_en), 64'(1));
    #2 rst_n = 1'b1;
    #1;
    check_idle_zero("rst_mid_async");
    check("rst_mid_sel_a", 64'(bus.sel_a), 64'(0));
    @(posedge clk); #1;
    check_idle_zero("rst_mid_next");
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_idle", 64'(bus.busy), 64'(0));

    rand_counts();
    do_run(5'($urandom_range(0, 31)), 500, 1000, "abort");

    rand_counts();
    do_run(5'($urandom_range(0, 31)), 0, 0, "fresh");

    // start and abort together while idle must not launch a run.
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sa_busy_%0d", i), 64'(bus.busy), 64'(0));
      check($sformatf("sa_clr_%0d", i),  64'(bus.cnt_clr), 64'(0));
      @(posedge clk); #1;
    end

    rand_counts();
    do_run(5'($urandom_range(0, 31)), 0, 0, "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/puf_measure_ctrl.md
Name: puf_measure_ctrl

Overview:
Sequencer for the ring-oscillator PUF datapath. It walks a 5-bit challenge base through N_BITS oscillator-pair measurements. For each bit it drives both mux selects, clears the two edge counters, gates the oscillators for a fixed clk-timed window, and latches the comparison result as one response bit. It sits between the pin interface (challenge/start) and the two oscillator-bank/counter slices.

Parameters:
N_BITS, 8, response bits produced per run (1..16)
CW, 32, width of count_a/count_b
CLR_CYCLES, 2, cycles cnt_clr held high per bit (>=1)
SETTLE_CYCLES, 4, cycles after clear with new selects before oscillators enabled (>=1)
WINDOW_CYCLES, 256, cycles osc_en held high per bit (>=1)
SYNC_CYCLES, 4, cycles after osc_en drops before counts are sampled (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
start  in  1  begin run; sampled only in IDLE
abort  in  1  cancel run in progress
chal_base  in  5  challenge base, latched on accepted start
count_a  in  CW  edge count from bank A counter
count_b  in  CW  edge count from bank B counter
sel_a  out  5  bank A oscillator select
sel_b  out  5  bank B oscillator select
osc_en  out  1  oscillator enable, both banks
cnt_clr  out  1  counter clear, both banks
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, run complete
response  out  N_BITS  PUF response, valid from done until next accepted start
tie_flag  out  1  sticky: some bit had count_a == count_b this run

Behaviour:
- Reset rst_n: asynchronous, active-high. On reset: state IDLE, all outputs 0, bit index k=0.
- States: IDLE, CLEAR, SETTLE, MEASURE, HOLD, COMPARE, DONE.
- IDLE: start=1 and abort=0 -> CLEAR next cycle. On that edge: latch chal_base, clear response, tie_flag and k.
- Selects for bit k, computed in 5-bit modulo-32 arithmetic:
  - sel_a = chal_base + 2k
  - sel_b = chal_base + 2k + 1
  - Selects update on entry to CLEAR and are held constant through COMPARE.
- CLEAR: cnt_clr=1, osc_en=0, for CLR_CYCLES cycles -> SETTLE.
- SETTLE: cnt_clr=0, osc_en=0, for SETTLE_CYCLES cycles -> MEASURE.
- MEASURE: osc_en=1 for exactly WINDOW_CYCLES cycles -> HOLD.
- HOLD: osc_en=0 for SYNC_CYCLES cycles, letting counters quiesce -> COMPARE.
- COMPARE: one cycle.
  - Sample count_a and count_b as unsigned values.
  - response[k] = (count_a > count_b).
  - If count_a == count_b: response[k]=0 and tie_flag set.
  - If k == N_BITS-1 -> DONE; else k++ -> CLEAR.
- DONE: done=1 for one cycle -> IDLE. response and tie_flag hold until the next accepted start.
- Latency: with P = CLR_CYCLES+SETTLE_CYCLES+WINDOW_CYCLES+SYNC_CYCLES+1, done is high in cycle 1+N_BITS*P after the start-sampling edge. Defaults: P=267, done at cycle 2137.
- start while busy: ignored, with no effect on state or latched challenge.
- abort in any non-IDLE state, including DONE: IDLE next cycle; osc_en=0, cnt_clr=0, response=0, tie_flag=0, no done pulse.
- start and abort together in IDLE: abort wins, stays IDLE.
- osc_en and cnt_clr are never high in the same cycle; all outputs are registered (glitch-free).
- Reset mid-run: immediate return to reset values, no done.

Decomposition:
- Shared package puf_pkg:
  - state enum
  - SEL_W=5
  - default timing constants (CLR/SETTLE/WINDOW/SYNC)
  - challenge-offset helper (base+2k, base+2k+1 mod 32)
- Sub-module puf_phase_timer: down-counter, width clog2 of the largest phase parameter. Loaded on each state entry; asserts expire when the count reaches 1. The FSM uses expire for every timed transition.

Test Plan:
- Reset during MEASURE with osc_en=1 -> next sampled cycle shows all outputs 0, state IDLE; a later start runs normally.
- Defaults, chal_base=5'd30, count_a=100/count_b=50 for even k, 50/100 for odd k:
  - response=8'b01010101
  - done at cycle 2137
  - tie_flag=0
  - sel pairs (30,31),(0,1),(2,3)...(12,13)
- count_a=count_b=77 on bit 3 only, others a>b -> response=8'b11110111, tie_flag=1.
- Phase-level check of one bit:
  - cnt_clr high exactly 2 cycles
  - osc_en high exactly 256 consecutive cycles, starting 4 cycles after cnt_clr falls
  - osc_en and cnt_clr never overlap
- start pulsed again at cycle 500 -> ignored, with chal_base unchanged in sel outputs. abort at cycle 1000 -> IDLE next cycle, osc_en=0, response=0, no done; a fresh start then completes normally.
- start and abort asserted together in IDLE -> busy stays 0, no CLEAR entry.
